// File: rtl/mul_add_fsm.sv
// Sequential shift-add multiplier with final accumulate: product = M*Q + addend.
// Latency 2N+1 cycles from the accepting edge; start is sampled only when idle and ignored while busy.
module mul_add_fsm #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    input  logic [N-1:0]     addend,
    output logic [2*N-1:0]   product,
    output logic             ready,
    output logic             busy
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        SOMA    = 2'd1,
        DESLOCA = 2'd2,
        ACUMULA = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     m_q, m_d;
    logic [N-1:0]     r_q, r_d;
    logic             c_q, c_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2*N-1:0]   product_q, product_d;
    logic             ready_q, ready_d;

    logic [N:0]       sum;
    logic [CW-1:0]    count_inc;

    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, m_q};
        count_inc = count_q + CW'(1);

        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        r_d       = r_q;
        c_d       = c_q;
        count_d   = count_q;
        product_d = product_q;
        ready_d   = ready_q;

        case (state_q)
            ESPERA: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    r_d     = addend;
                    a_d     = '0;
                    c_d     = 1'b0;
                    count_d = '0;
                    ready_d = 1'b0;
                    state_d = SOMA;
                end
            end
            SOMA: begin
                if (q_q[0]) begin
                    {c_d, a_d} = sum;
                end
                state_d = DESLOCA;
            end
            DESLOCA: begin
                // Carry shifts into A's MSB, A's LSB into Q; consumed multiplier bit drops out.
                {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[N-1:1]};
                count_d         = count_inc;
                state_d         = (count_inc == CW'(N)) ? ACUMULA : SOMA;
            end
            ACUMULA: begin
                // Max result 2^2N - 2^N fits, so no carry-out is kept.
                product_d = {a_q, q_q} + {{N{1'b0}}, r_q};
                ready_d   = 1'b1;
                state_d   = ESPERA;
            end
            default: begin
                state_d = ESPERA;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ESPERA;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            r_q       <= '0;
            c_q       <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            r_q       <= r_d;
            c_q       <= c_d;
            count_q   <= count_d;
            product_q <= product_d;
            ready_q   <= ready_d;
        end
    end

    assign product = product_q;
    assign ready   = ready_q;
    assign busy    = (state_q != ESPERA);

endmodule

// File: tb/tb_mul_add_fsm.sv
// Directed bench for mul_add_fsm (N=8): latency, corner products, divider round trip,
// back-to-back starts and mid-operation reset.
module tb_mul_add_fsm;

    localparam int N = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic [N-1:0]     addend;
    logic [2*N-1:0]   product;
    logic             ready;
    logic             busy;

    int n_cmp;
    int n_err;

    mul_add_fsm #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .product      (product),
        .ready        (ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands, pulse start for one edge (E0); returns at E0+#1.
    task automatic launch(input logic [N-1:0] m, input logic [N-1:0] q, input logic [N-1:0] a);
        multiplicand = m;
        multiplier   = q;
        addend       = a;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // From E0+#1, step cycles until ready; lat=-1 on timeout.
    task automatic wait_ready(output int lat, output int busy_cyc, output logic stable);
        logic [2*N-1:0] p0;
        p0       = product;
        busy_cyc = busy ? 1 : 0;
        stable   = 1'b1;
        lat      = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = k;
                break;
            end
            if (busy) busy_cyc++;
            if (product !== p0) stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        addend       = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (product !== 16'd0 || ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: product=%0d ready=%b busy=%b, want 0/0/0", product, ready, busy);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_start: ready=%b busy=%b, want 0/0", ready, busy);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        logic st;
        launch(8'd13, 8'd11, 8'd7);
        n_cmp++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_accept: busy=%b ready=%b, want 1/0", busy, ready);
        end
        wait_ready(lat, bc, st);
        n_cmp++;
        if (lat !== 17) begin
            n_err++;
            $display("FAIL basic_latency: got %0d cycles, want 17", lat);
        end
        n_cmp++;
        if (bc !== 17) begin
            n_err++;
            $display("FAIL basic_busy_cycles: got %0d, want 17", bc);
        end
        n_cmp++;
        if (product !== 16'd150 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_product: got %0d busy=%b, want 150 busy=0", product, busy);
        end
        n_cmp++;
        if (st !== 1'b1) begin
            n_err++;
            $display("FAIL basic_hold_prev: product moved during computation, want stable 0");
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (product !== 16'd150 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_result_hold: product=%0d ready=%b, want 150/1", product, ready);
        end
    endtask

    task automatic test_corners();
        logic [N-1:0]   vm [4] = '{8'd255, 8'd255, 8'd0,   8'd200};
        logic [N-1:0]   vq [4] = '{8'd255, 8'd255, 8'd200, 8'd0};
        logic [N-1:0]   va [4] = '{8'd255, 8'd0,   8'd5,   8'd0};
        logic [2*N-1:0] ve [4] = '{16'hFF00, 16'hFE01, 16'd5, 16'd0};
        logic [2*N-1:0] prev;
        int lat, bc;
        logic st;
        for (int i = 0; i < 4; i++) begin
            prev = product;
            launch(vm[i], vq[i], va[i]);
            n_cmp++;
            if (ready !== 1'b0) begin
                n_err++;
                $display("FAIL corner%0d_ready_fall: ready=%b, want 0", i, ready);
            end
            wait_ready(lat, bc, st);
            n_cmp++;
            if (lat !== 17 || product !== ve[i]) begin
                n_err++;
                $display("FAIL corner%0d: lat=%0d product=%0d, want lat=17 product=%0d", i, lat, product, ve[i]);
            end
            n_cmp++;
            if (st !== 1'b1) begin
                n_err++;
                $display("FAIL corner%0d_hold_prev: product left %0d before ready", i, prev);
            end
        end
    endtask

    task automatic test_divider_roundtrip();
        int lat, bc;
        logic st;
        logic [N-1:0] dvd, dvs, quo, rem;
        launch(8'd28, 8'd7, 8'd4);
        wait_ready(lat, bc, st);
        n_cmp++;
        if (product !== 16'd200) begin
            n_err++;
            $display("FAIL roundtrip_200_7: got %0d, want 200", product);
        end
        for (int i = 0; i < 256; i++) begin
            dvd = 8'($urandom_range(0, 255));
            dvs = 8'($urandom_range(1, 255));
            quo = dvd / dvs;
            rem = dvd % dvs;
            launch(quo, dvs, rem);
            wait_ready(lat, bc, st);
            n_cmp++;
            if (lat !== 17 || product !== {8'd0, dvd}) begin
                n_err++;
                $display("FAIL roundtrip_sweep%0d: %0d/%0d q=%0d r=%0d -> product=%0d lat=%0d, want %0d lat=17",
                         i, dvd, dvs, quo, rem, product, lat, dvd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, gap;
        logic st;
        launch(8'd2, 8'd3, 8'd1);
        // Hold start high with new operands while busy; they must be ignored.
        multiplicand = 8'd9;
        multiplier   = 8'd9;
        addend       = 8'd9;
        start        = 1'b1;
        wait_ready(lat, bc, st);
        n_cmp++;
        if (lat !== 17 || product !== 16'd7) begin
            n_err++;
            $display("FAIL b2b_first: lat=%0d product=%0d, want 17/7", lat, product);
        end
        multiplicand = 8'd4;
        multiplier   = 8'd6;
        addend       = 8'd2;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0 || busy !== 1'b1 || product !== 16'd7) begin
            n_err++;
            $display("FAIL b2b_ready_pulse: ready=%b busy=%b product=%0d, want 0/1/7", ready, busy, product);
        end
        multiplicand = 8'd250;
        multiplier   = 8'd250;
        addend       = 8'd250;
        gap = 1;
        wait_ready(lat, bc, st);
        gap += lat;
        n_cmp++;
        if (gap !== 18 || product !== 16'd26) begin
            n_err++;
            $display("FAIL b2b_second: period=%0d product=%0d, want 18/26", gap, product);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: ready=%b busy=%b, want 1/0", ready, busy);
        end
    endtask

    task automatic test_mid_reset();
        int lat, bc;
        logic st;
        launch(8'd100, 8'd100, 8'd100);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (product !== 16'd0 || ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_async: product=%0d ready=%b busy=%b, want 0/0/0", product, ready, busy);
        end
        @(posedge clk);
        #1;
        reset        = 1'b0;
        multiplicand = 8'd3;
        multiplier   = 8'd4;
        addend       = 8'd1;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_first_start: busy=%b, want 1", busy);
        end
        wait_ready(lat, bc, st);
        n_cmp++;
        if (lat !== 17 || product !== 16'd13) begin
            n_err++;
            $display("FAIL midreset_fresh_op: lat=%0d product=%0d, want 17/13", lat, product);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_corners();
        test_divider_roundtrip();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
